// File: rtl/led_ownership_arbiter.sv
// led_ownership_arbiter
//    Glue between the BeMicro MAX 10 board I/O and the Nios II system.
//    - Debounces the four raw active-low pushbuttons for the CPU button PIO.
//    - Arbitrates the eight user LEDs between the CPU LED PIO and a hardware
//      status source with a round-robin grant FSM and a bounded hold time
//      whenever the other requester is waiting.
//    - Shows an idle pattern on the LEDs when nobody owns them.
//
// Optional feature macro: LED_ARB_HEARTBEAT_EN
//    defined   : in IDLE, USER_LED[1] blinks with a half-period of HEARTBEAT_HALF
//                cycles from a free-running counter; the other LEDs stay off.
//    undefined : in IDLE all LEDs are off and no heartbeat counter is built.
//
// Ports
//    SYS_CLK   in   1      system clock
//    reset_n   in   1      asynchronous active-low reset
//    PB        in   [4:1]  raw pushbuttons, active-low, asynchronous
//    pb_db     out  [4:1]  debounced buttons, active-low
//    pb_press  out  [4:1]  one-cycle pulse on each debounced press (1->0)
//    cpu_req   in   1      CPU requests the LEDs
//    cpu_led   in   [7:0]  CPU pattern, active-high
//    cpu_gnt   out  1      CPU owns the LEDs
//    hw_req    in   1      hardware source requests the LEDs
//    hw_led    in   [7:0]  hardware pattern, active-high
//    hw_gnt    out  1      hardware source owns the LEDs
//    USER_LED  out  [8:1]  board LEDs, active-low, registered

module led_ownership_arbiter #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int MAX_HOLD        = 50000000,
   parameter int HEARTBEAT_HALF  = 25000000
) (
   input  logic       SYS_CLK,
   input  logic       reset_n,
   input  logic [4:1] PB,
   output logic [4:1] pb_db,
   output logic [4:1] pb_press,
   input  logic       cpu_req,
   input  logic [7:0] cpu_led,
   output logic       cpu_gnt,
   input  logic       hw_req,
   input  logic [7:0] hw_led,
   output logic       hw_gnt,
   output logic [8:1] USER_LED
);

   // Counters below 2 would collapse to zero width.
   if (DEBOUNCE_CYCLES < 2 || MAX_HOLD < 2 || HEARTBEAT_HALF < 2) begin : g_bad_params
      $error("led_ownership_arbiter: DEBOUNCE_CYCLES, MAX_HOLD and HEARTBEAT_HALF must be >= 2");
   end

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(MAX_HOLD);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CPU  = 2'd1;
   localparam logic [1:0] S_HW   = 2'd2;

   logic [4:1]      sync1_q, sync1_d;
   logic [4:1]      sync2_q, sync2_d;
   logic [4:1]      stable_q, stable_d;
   logic [4:1]      press_q, press_d;
   logic [DB_W-1:0] db_cnt_q [4:1];
   logic [DB_W-1:0] db_cnt_d [4:1];

   logic [1:0]        state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              rr_q, rr_d;
   logic [7:0]        led_q, led_d;
   logic [7:0]        idle_pattern;

   // Debounce: a button's counter only runs while its synchronized level
   // disagrees with the accepted level, so any bounce back to the accepted
   // level restarts the wait. A press pulse fires on the same edge the
   // accepted level falls.
   always_comb begin
      sync1_d = PB;
      sync2_d = sync1_q;
      for (int i = 1; i <= 4; i++) begin
         db_cnt_d[i] = '0;
         stable_d[i] = stable_q[i];
         press_d[i]  = 1'b0;
         if (sync2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               stable_d[i] = sync2_q[i];
               press_d[i]  = stable_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   // Grant FSM. rr_q records the last owner (1 = hardware), so a tie in IDLE
   // goes to the other side; its reset value hands the first tie to the CPU.
   // An owner is only revoked once its hold counter has saturated and the
   // other side is waiting.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cpu_req && hw_req) state_d = rr_q ? S_CPU : S_HW;
            else if (cpu_req)      state_d = S_CPU;
            else if (hw_req)       state_d = S_HW;
         end
         S_CPU: begin
            if (!cpu_req)                          state_d = hw_req ? S_HW : S_IDLE;
            else if (hw_req && hold_q == HOLD_LAST) state_d = S_HW;
         end
         S_HW: begin
            if (!hw_req)                            state_d = cpu_req ? S_CPU : S_IDLE;
            else if (cpu_req && hold_q == HOLD_LAST) state_d = S_CPU;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Hold counter restarts on every state entry and saturates while owned;
   // the round-robin pointer follows each new grant.
   always_comb begin
      hold_d = hold_q;
      rr_d   = rr_q;
      if (state_d != state_q) begin
         hold_d = '0;
         if (state_d == S_CPU)     rr_d = 1'b0;
         else if (state_d == S_HW) rr_d = 1'b1;
      end else if (state_q != S_IDLE && hold_q != HOLD_LAST) begin
         hold_d = hold_q + HOLD_W'(1);
      end
   end

`ifdef LED_ARB_HEARTBEAT_EN
   localparam int HB_W = $clog2(HEARTBEAT_HALF);
   localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_HALF - 1);

   logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
   logic            hb_q, hb_d;

   // Free-running heartbeat; it ignores the FSM so the blink phase depends
   // only on time since reset.
   always_comb begin
      hb_cnt_d = hb_cnt_q + HB_W'(1);
      hb_d     = hb_q;
      if (hb_cnt_q == HB_LAST) begin
         hb_cnt_d = '0;
         hb_d     = ~hb_q;
      end
   end

   always_ff @(posedge SYS_CLK or negedge reset_n) begin
      if (!reset_n) begin
         hb_cnt_q <= '0;
         hb_q     <= 1'b0;
      end else begin
         hb_cnt_q <= hb_cnt_d;
         hb_q     <= hb_d;
      end
   end

   assign idle_pattern = {7'h7F, ~hb_q};
`else
   assign idle_pattern = 8'hFF;
`endif

   // LED mux is registered from the current owner, so LEDs lag the grant by
   // one cycle and track owner data with one cycle of latency.
   always_comb begin
      case (state_q)
         S_CPU:   led_d = ~cpu_led;
         S_HW:    led_d = ~hw_led;
         default: led_d = idle_pattern;
      endcase
   end

   always_ff @(posedge SYS_CLK or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 4'hF;
         sync2_q  <= 4'hF;
         stable_q <= 4'hF;
         press_q  <= 4'h0;
         for (int i = 1; i <= 4; i++) db_cnt_q[i] <= '0;
         state_q  <= S_IDLE;
         hold_q   <= '0;
         rr_q     <= 1'b1;
         led_q    <= 8'hFF;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         press_q  <= press_d;
         for (int i = 1; i <= 4; i++) db_cnt_q[i] <= db_cnt_d[i];
         state_q  <= state_d;
         hold_q   <= hold_d;
         rr_q     <= rr_d;
         led_q    <= led_d;
      end
   end

   assign pb_db    = stable_q;
   assign pb_press = press_q;
   assign cpu_gnt  = (state_q == S_CPU);
   assign hw_gnt   = (state_q == S_HW);
   assign USER_LED = led_q;

endmodule

// File: tb/tb_led_ownership_arbiter.sv
// tb_led_ownership_arbiter
//    Directed bench for led_ownership_arbiter with small parameters.
//    Stimulus pushes expected values, tagged with the clock edge after which
//    they must hold, into a scoreboard queue; a monitor samples the DUT on
//    every falling edge and retires the entries due at that point.

module tb_led_ownership_arbiter;

   localparam int DEB  = 4;
   localparam int HOLD = 8;
   localparam int HB   = 5;

   localparam int SEL_PB_DB    = 0;
   localparam int SEL_PB_PRESS = 1;
   localparam int SEL_CPU_GNT  = 2;
   localparam int SEL_HW_GNT   = 3;
   localparam int SEL_LED      = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [4:1] pb = 4'hF;
   logic [4:1] pb_db;
   logic [4:1] pb_press;
   logic       cpu_req = 1'b0;
   logic [7:0] cpu_led = 8'h00;
   logic       cpu_gnt;
   logic       hw_req = 1'b0;
   logic [7:0] hw_led = 8'h00;
   logic       hw_gnt;
   logic [8:1] user_led;

   typedef struct {
      int         cyc;
      int         sel;
      logic [7:0] val;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   rel_cyc  = 0;
   int   checks   = 0;
   int   failures = 0;

   led_ownership_arbiter #(
      .DEBOUNCE_CYCLES (DEB),
      .MAX_HOLD        (HOLD),
      .HEARTBEAT_HALF  (HB)
   ) dut (
      .SYS_CLK  (clk),
      .reset_n  (reset_n),
      .PB       (pb),
      .pb_db    (pb_db),
      .pb_press (pb_press),
      .cpu_req  (cpu_req),
      .cpu_led  (cpu_led),
      .cpu_gnt  (cpu_gnt),
      .hw_req   (hw_req),
      .hw_led   (hw_led),
      .hw_gnt   (hw_gnt),
      .USER_LED (user_led)
   );

   always #5 clk = ~clk;

   // Edge counter: after posedge N, cyc == N.
   always @(posedge clk) cyc++;

   // Expected idle LED value after edge n, given the last reset release at
   // rel_cyc: the heartbeat bit flips every HB edges after release and the
   // LED register shows it one edge later.
   function automatic logic [7:0] idleLed(input int n);
      logic [7:0] v;
      v = 8'hFF;
`ifdef LED_ARB_HEARTBEAT_EN
      if ((((n - 1 - rel_cyc) / HB) % 2) == 1) v = 8'hFE;
`endif
      return v;
   endfunction

   task automatic pushExpect(input int c, input int sel, input logic [7:0] v, input string n);
      exp_t e;
      e.cyc  = c;
      e.sel  = sel;
      e.val  = v;
      e.name = n;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input logic cr, input logic [7:0] cl,
                                input logic hr, input logic [7:0] hl);
      cpu_req = cr;
      cpu_led = cl;
      hw_req  = hr;
      hw_led  = hl;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input exp_t e);
      logic [7:0] act;
      case (e.sel)
         SEL_PB_DB:    act = {4'h0, pb_db};
         SEL_PB_PRESS: act = {4'h0, pb_press};
         SEL_CPU_GNT:  act = {7'h00, cpu_gnt};
         SEL_HW_GNT:   act = {7'h00, hw_gnt};
         default:      act = user_led;
      endcase
      checks++;
      if (act !== e.val) begin
         failures++;
         $display("[TB] FAIL %s edge=%0d actual=%h expected=%h", e.name, e.cyc, act, e.val);
      end
   endtask

   // Monitor: retire every expectation due after the most recent edge.
   always @(negedge clk) begin
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].cyc == cyc) begin
            checkOutput(sb[i]);
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s edge=%0d actual=unsampled expected=%h", sb[i].name, sb[i].cyc, sb[i].val);
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c;
      int p;
      int q;

      // Reset values while reset_n is low.
      waitCycles(1);
      pushExpect(cyc, SEL_PB_DB,    8'h0F, "rst_pb_db");
      pushExpect(cyc, SEL_PB_PRESS, 8'h00, "rst_pb_press");
      pushExpect(cyc, SEL_CPU_GNT,  8'h00, "rst_cpu_gnt");
      pushExpect(cyc, SEL_HW_GNT,   8'h00, "rst_hw_gnt");
      pushExpect(cyc, SEL_LED,      8'hFF, "rst_led");
      waitCycles(1);
      reset_n = 1'b1;
      rel_cyc = cyc;
      waitCycles(1);

      // CPU alone: grant after one edge, LEDs one edge later, data tracking.
      $display("[TB] cpu-only grant");
      c = cyc;
      applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00);
      pushExpect(c,     SEL_CPU_GNT, 8'h00, "a_gnt_not_yet");
      pushExpect(c + 1, SEL_CPU_GNT, 8'h01, "a_cpu_gnt");
      pushExpect(c + 1, SEL_HW_GNT,  8'h00, "a_hw_gnt");
      pushExpect(c + 2, SEL_LED,     8'h5A, "a_led");
      waitCycles(2);
      applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00);
      pushExpect(c + 2, SEL_LED,     8'h5A, "a_led_lag");
      pushExpect(c + 3, SEL_LED,     8'hC3, "a_led_follow");
      waitCycles(1);
      applyStimulus(1'b0, 8'h3C, 1'b0, 8'h00);
      pushExpect(c + 4, SEL_CPU_GNT, 8'h00, "a_release");
      pushExpect(c + 5, SEL_LED,     idleLed(c + 5), "a_idle_led");
      waitCycles(3);

      // Reset asserted mid-grant drops everything without a clock edge.
      $display("[TB] reset mid-grant");
      c = cyc;
      applyStimulus(1'b1, 8'h81, 1'b0, 8'h00);
      pushExpect(c + 1, SEL_CPU_GNT, 8'h01, "b_gnt");
      pushExpect(c + 2, SEL_LED,     8'h7E, "b_led");
      waitCycles(3);
      reset_n = 1'b0;
      pushExpect(c + 3, SEL_CPU_GNT, 8'h00, "b_rst_gnt");
      pushExpect(c + 3, SEL_LED,     8'hFF, "b_rst_led");
      waitCycles(1);
      pushExpect(c + 4, SEL_CPU_GNT, 8'h00, "b_rst_held");
      reset_n = 1'b1;
      rel_cyc = cyc;
      pushExpect(c + 5, SEL_CPU_GNT, 8'h01, "b_regrant");
      pushExpect(c + 6, SEL_LED,     8'h7E, "b_led_again");
      waitCycles(2);
      applyStimulus(1'b0, 8'h81, 1'b0, 8'h00);
      waitCycles(3);

      // Contention from reset: CPU wins the tie, then timeouts alternate.
      $display("[TB] contention and timeout");
      reset_n = 1'b0;
      waitCycles(1);
      reset_n = 1'b1;
      rel_cyc = cyc;
      c = cyc;
      applyStimulus(1'b1, 8'hA5, 1'b1, 8'h0F);
      pushExpect(c + 1,  SEL_CPU_GNT, 8'h01, "c_tie_cpu");
      pushExpect(c + 1,  SEL_HW_GNT,  8'h00, "c_tie_hw");
      pushExpect(c + 2,  SEL_LED,     8'h5A, "c_cpu_led");
      pushExpect(c + 8,  SEL_CPU_GNT, 8'h01, "c_cpu_before_timeout");
      pushExpect(c + 8,  SEL_HW_GNT,  8'h00, "c_hw_before_timeout");
      pushExpect(c + 9,  SEL_CPU_GNT, 8'h00, "c_cpu_revoked");
      pushExpect(c + 9,  SEL_HW_GNT,  8'h01, "c_hw_granted");
      pushExpect(c + 9,  SEL_LED,     8'h5A, "c_led_lag");
      pushExpect(c + 10, SEL_LED,     8'hF0, "c_hw_led");
      pushExpect(c + 16, SEL_HW_GNT,  8'h01, "c_hw_before_timeout");
      pushExpect(c + 17, SEL_HW_GNT,  8'h00, "c_hw_revoked");
      pushExpect(c + 17, SEL_CPU_GNT, 8'h01, "c_cpu_regained");
      pushExpect(c + 18, SEL_LED,     8'h5A, "c_cpu_led_again");
      waitCycles(17);

      // CPU releases while HW waits: direct handover, then HW releases to IDLE.
      applyStimulus(1'b0, 8'hA5, 1'b1, 8'h0F);
      pushExpect(c + 18, SEL_HW_GNT,  8'h01, "d_handover_hw");
      pushExpect(c + 18, SEL_CPU_GNT, 8'h00, "d_handover_cpu");
      pushExpect(c + 19, SEL_LED,     8'hF0, "d_hw_led");
      waitCycles(2);
      applyStimulus(1'b0, 8'hA5, 1'b0, 8'h0F);
      pushExpect(c + 20, SEL_HW_GNT,  8'h00, "d_idle_hw");
      pushExpect(c + 20, SEL_CPU_GNT, 8'h00, "d_idle_cpu");
      for (int n = c + 21; n <= c + 32; n++) pushExpect(n, SEL_LED, idleLed(n), "d_idle_led");
      waitCycles(13);

      // Debounce: PB[2] bounces 1-0-1-0 at 2-cycle spacing, then holds low.
      $display("[TB] debounce");
      p = cyc;
      for (int n = p; n <= p + 9; n++) begin
         pushExpect(n, SEL_PB_DB,    8'h0F, "e_db_stable");
         pushExpect(n, SEL_PB_PRESS, 8'h00, "e_no_press");
      end
      pushExpect(p + 10, SEL_PB_DB,    8'h0D, "e_db_pressed");
      pushExpect(p + 10, SEL_PB_PRESS, 8'h02, "e_press_pulse");
      pushExpect(p + 11, SEL_PB_DB,    8'h0D, "e_db_held");
      pushExpect(p + 11, SEL_PB_PRESS, 8'h00, "e_press_single");
      pb = 4'hD;
      waitCycles(2);
      pb = 4'hF;
      waitCycles(2);
      pb = 4'hD;
      waitCycles(8);

      // Release: pb_db returns high, no press pulse.
      q = cyc;
      pb = 4'hF;
      pushExpect(q + 5, SEL_PB_DB,    8'h0D, "e_release_wait");
      pushExpect(q + 6, SEL_PB_DB,    8'h0F, "e_released");
      pushExpect(q + 6, SEL_PB_PRESS, 8'h00, "e_no_release_press");
      waitCycles(8);

      for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain pending=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
